// File: rtl/fdw_pipe_regs.sv
// F (predicted PC), D (fetch->decode) and W (memory->writeback) pipeline registers of the Y86-64 core.
// Optional FDW_HALT_FREEZE_EN: a HLT/INS status captured in W freezes F, D and W until reset.
module fdw_pipe_regs #(
   parameter int                W_DATA   = 64,
   parameter logic [W_DATA-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              F_stall,
   input  logic              D_stall,
   input  logic              D_bubble,
   input  logic              W_stall,
   input  logic [W_DATA-1:0] pred_PC,
   output logic [W_DATA-1:0] F_predPC,
   input  logic [2:0]        f_stat,
   input  logic [3:0]        f_iCode,
   input  logic [3:0]        f_iFun,
   input  logic [3:0]        f_rA,
   input  logic [3:0]        f_rB,
   input  logic [W_DATA-1:0] f_valC,
   input  logic [W_DATA-1:0] f_valP,
   output logic [2:0]        D_stat,
   output logic [3:0]        D_iCode,
   output logic [3:0]        D_iFun,
   output logic [3:0]        D_rA,
   output logic [3:0]        D_rB,
   output logic [W_DATA-1:0] D_valC,
   output logic [W_DATA-1:0] D_valP,
   input  logic [2:0]        m_stat,
   input  logic [3:0]        M_iCode,
   input  logic [3:0]        M_rA,
   input  logic [3:0]        M_rB,
   input  logic [W_DATA-1:0] M_valC,
   input  logic [W_DATA-1:0] M_valP,
   input  logic [W_DATA-1:0] M_valA,
   input  logic [W_DATA-1:0] M_valB,
   input  logic [W_DATA-1:0] M_valE,
   input  logic [W_DATA-1:0] m_valM,
   input  logic              M_Cnd,
   output logic [2:0]        W_stat,
   output logic [3:0]        W_iCode,
   output logic [3:0]        W_rA,
   output logic [3:0]        W_rB,
   output logic [W_DATA-1:0] W_valC,
   output logic [W_DATA-1:0] W_valP,
   output logic [W_DATA-1:0] W_valA,
   output logic [W_DATA-1:0] W_valB,
   output logic [W_DATA-1:0] W_valE,
   output logic [W_DATA-1:0] W_valM,
   output logic              W_Cnd
);

   localparam logic [2:0] STAT_AOK = 3'b001;
   localparam logic [2:0] STAT_INS = 3'b010;
   localparam logic [2:0] STAT_HLT = 3'b100;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] R_NONE   = 4'hF;

   logic [W_DATA-1:0] r_F_predPC;

   logic [2:0]        r_D_stat;
   logic [3:0]        r_D_iCode;
   logic [3:0]        r_D_iFun;
   logic [3:0]        r_D_rA;
   logic [3:0]        r_D_rB;
   logic [W_DATA-1:0] r_D_valC;
   logic [W_DATA-1:0] r_D_valP;

   logic [2:0]        r_W_stat;
   logic [3:0]        r_W_iCode;
   logic [3:0]        r_W_rA;
   logic [3:0]        r_W_rB;
   logic [W_DATA-1:0] r_W_valC;
   logic [W_DATA-1:0] r_W_valP;
   logic [W_DATA-1:0] r_W_valA;
   logic [W_DATA-1:0] r_W_valB;
   logic [W_DATA-1:0] r_W_valE;
   logic [W_DATA-1:0] r_W_valM;
   logic              r_W_Cnd;

   logic w_freeze;
   logic w_F_hold;
   logic w_D_hold;
   logic w_W_hold;

`ifdef FDW_HALT_FREEZE_EN
   // Freeze is driven from the registered W status, so it takes effect the edge after capture.
   assign w_freeze = ((r_W_stat & (STAT_HLT | STAT_INS)) != 3'b000);
`else
   assign w_freeze = 1'b0;
`endif

   assign w_F_hold = F_stall | w_freeze;
   assign w_D_hold = D_stall | w_freeze;
   assign w_W_hold = W_stall | w_freeze;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_F_predPC <= RESET_PC;
      end else if (!w_F_hold) begin
         r_F_predPC <= pred_PC;
      end
   end

   // Stall outranks bubble: a stalled D keeps its instruction even if a bubble is also requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_D_stat  <= STAT_AOK;
         r_D_iCode <= I_NOP;
         r_D_iFun  <= 4'h0;
         r_D_rA    <= R_NONE;
         r_D_rB    <= R_NONE;
         r_D_valC  <= '0;
         r_D_valP  <= '0;
      end else if (!w_D_hold) begin
         if (D_bubble) begin
            r_D_stat  <= STAT_AOK;
            r_D_iCode <= I_NOP;
            r_D_iFun  <= 4'h0;
            r_D_rA    <= R_NONE;
            r_D_rB    <= R_NONE;
            r_D_valC  <= '0;
            r_D_valP  <= '0;
         end else begin
            r_D_stat  <= f_stat;
            r_D_iCode <= f_iCode;
            r_D_iFun  <= f_iFun;
            r_D_rA    <= f_rA;
            r_D_rB    <= f_rB;
            r_D_valC  <= f_valC;
            r_D_valP  <= f_valP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_W_stat  <= STAT_AOK;
         r_W_iCode <= I_NOP;
         r_W_rA    <= R_NONE;
         r_W_rB    <= R_NONE;
         r_W_valC  <= '0;
         r_W_valP  <= '0;
         r_W_valA  <= '0;
         r_W_valB  <= '0;
         r_W_valE  <= '0;
         r_W_valM  <= '0;
         r_W_Cnd   <= 1'b0;
      end else if (!w_W_hold) begin
         r_W_stat  <= m_stat;
         r_W_iCode <= M_iCode;
         r_W_rA    <= M_rA;
         r_W_rB    <= M_rB;
         r_W_valC  <= M_valC;
         r_W_valP  <= M_valP;
         r_W_valA  <= M_valA;
         r_W_valB  <= M_valB;
         r_W_valE  <= M_valE;
         r_W_valM  <= m_valM;
         r_W_Cnd   <= M_Cnd;
      end
   end

   assign F_predPC = r_F_predPC;

   assign D_stat   = r_D_stat;
   assign D_iCode  = r_D_iCode;
   assign D_iFun   = r_D_iFun;
   assign D_rA     = r_D_rA;
   assign D_rB     = r_D_rB;
   assign D_valC   = r_D_valC;
   assign D_valP   = r_D_valP;

   assign W_stat   = r_W_stat;
   assign W_iCode  = r_W_iCode;
   assign W_rA     = r_W_rA;
   assign W_rB     = r_W_rB;
   assign W_valC   = r_W_valC;
   assign W_valP   = r_W_valP;
   assign W_valA   = r_W_valA;
   assign W_valB   = r_W_valB;
   assign W_valE   = r_W_valE;
   assign W_valM   = r_W_valM;
   assign W_Cnd    = r_W_Cnd;

endmodule

// File: tb/tb_fdw_pipe_regs.sv
// Scoreboard bench for fdw_pipe_regs: expected register contents are queued at drive time and checked after the edge.
module tb_fdw_pipe_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        F_stall, D_stall, D_bubble, W_stall;
   logic [63:0] pred_PC, F_predPC;
   logic [2:0]  f_stat, D_stat, m_stat, W_stat;
   logic [3:0]  f_iCode, f_iFun, f_rA, f_rB;
   logic [3:0]  D_iCode, D_iFun, D_rA, D_rB;
   logic [63:0] f_valC, f_valP, D_valC, D_valP;
   logic [3:0]  M_iCode, M_rA, M_rB, W_iCode, W_rA, W_rB;
   logic [63:0] M_valC, M_valP, M_valA, M_valB, M_valE, m_valM;
   logic [63:0] W_valC, W_valP, W_valA, W_valB, W_valE, W_valM;
   logic        M_Cnd, W_Cnd;

   fdw_pipe_regs dut (
      .clk(clk), .rst_n(rst_n),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .W_stall(W_stall),
      .pred_PC(pred_PC), .F_predPC(F_predPC),
      .f_stat(f_stat), .f_iCode(f_iCode), .f_iFun(f_iFun), .f_rA(f_rA), .f_rB(f_rB),
      .f_valC(f_valC), .f_valP(f_valP),
      .D_stat(D_stat), .D_iCode(D_iCode), .D_iFun(D_iFun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP),
      .m_stat(m_stat), .M_iCode(M_iCode), .M_rA(M_rA), .M_rB(M_rB),
      .M_valC(M_valC), .M_valP(M_valP), .M_valA(M_valA), .M_valB(M_valB),
      .M_valE(M_valE), .m_valM(m_valM), .M_Cnd(M_Cnd),
      .W_stat(W_stat), .W_iCode(W_iCode), .W_rA(W_rA), .W_rB(W_rB),
      .W_valC(W_valC), .W_valP(W_valP), .W_valA(W_valA), .W_valB(W_valB),
      .W_valE(W_valE), .W_valM(W_valM), .W_Cnd(W_Cnd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] fpc;
      logic [2:0]  dstat;
      logic [3:0]  dic, dif, dra, drb;
      logic [63:0] dvc, dvp;
      logic [2:0]  wstat;
      logic [3:0]  wic, wra, wrb;
      logic [63:0] wvc, wvp, wva, wvb, wve, wvm;
      logic        wcnd;
   } exp_t;

   exp_t q[$];
   exp_t mdl;
   int   total = 0;
   int   bad   = 0;
   int   n_step = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (step %0d)", tag, obs, exp, n_step);
      end
   endtask

   function automatic exp_t bubble_state();
      exp_t e;
      e = '0;
      e.dstat = 3'b001; e.dic = 4'h1; e.dra = 4'hF; e.drb = 4'hF;
      e.wstat = 3'b001; e.wic = 4'h1; e.wra = 4'hF; e.wrb = 4'hF;
      return e;
   endfunction

   task automatic check_all(input exp_t e);
      chk("F_predPC", F_predPC, e.fpc);
      chk("D_stat",   {61'd0, D_stat},  {61'd0, e.dstat});
      chk("D_iCode",  {60'd0, D_iCode}, {60'd0, e.dic});
      chk("D_iFun",   {60'd0, D_iFun},  {60'd0, e.dif});
      chk("D_rA",     {60'd0, D_rA},    {60'd0, e.dra});
      chk("D_rB",     {60'd0, D_rB},    {60'd0, e.drb});
      chk("D_valC",   D_valC, e.dvc);
      chk("D_valP",   D_valP, e.dvp);
      chk("W_stat",   {61'd0, W_stat},  {61'd0, e.wstat});
      chk("W_iCode",  {60'd0, W_iCode}, {60'd0, e.wic});
      chk("W_rA",     {60'd0, W_rA},    {60'd0, e.wra});
      chk("W_rB",     {60'd0, W_rB},    {60'd0, e.wrb});
      chk("W_valC",   W_valC, e.wvc);
      chk("W_valP",   W_valP, e.wvp);
      chk("W_valA",   W_valA, e.wva);
      chk("W_valB",   W_valB, e.wvb);
      chk("W_valE",   W_valE, e.wve);
      chk("W_valM",   W_valM, e.wvm);
      chk("W_Cnd",    {63'd0, W_Cnd},   {63'd0, e.wcnd});
   endtask

   // Predict the next register state from the current inputs, queue it, clock, then compare.
   task automatic step();
      exp_t e;
      logic freeze;
      exp_t bub;
      bub = bubble_state();
`ifdef FDW_HALT_FREEZE_EN
      freeze = mdl.wstat[2] | mdl.wstat[1];
`else
      freeze = 1'b0;
`endif
      if (!freeze) begin
         if (!F_stall) mdl.fpc = pred_PC;
         if (!D_stall) begin
            if (D_bubble) begin
               mdl.dstat = bub.dstat; mdl.dic = bub.dic; mdl.dif = bub.dif;
               mdl.dra = bub.dra; mdl.drb = bub.drb; mdl.dvc = '0; mdl.dvp = '0;
            end else begin
               mdl.dstat = f_stat; mdl.dic = f_iCode; mdl.dif = f_iFun;
               mdl.dra = f_rA; mdl.drb = f_rB; mdl.dvc = f_valC; mdl.dvp = f_valP;
            end
         end
         if (!W_stall) begin
            mdl.wstat = m_stat; mdl.wic = M_iCode; mdl.wra = M_rA; mdl.wrb = M_rB;
            mdl.wvc = M_valC; mdl.wvp = M_valP; mdl.wva = M_valA; mdl.wvb = M_valB;
            mdl.wve = M_valE; mdl.wvm = m_valM; mdl.wcnd = M_Cnd;
         end
      end
      q.push_back(mdl);
      @(posedge clk);
      #1;
      e = q.pop_front();
      n_step++;
      check_all(e);
      $display("step %0d: Fs=%0b Ds=%0b Db=%0b Ws=%0b F_predPC=%0h D_iCode=%0h W_iCode=%0h W_stat=%0b",
               n_step, F_stall, D_stall, D_bubble, W_stall, F_predPC, D_iCode, W_iCode, W_stat);
   endtask

   task automatic idle_ctl();
      F_stall = 0; D_stall = 0; D_bubble = 0; W_stall = 0;
   endtask

   function automatic logic [2:0] pick_stat(input int r);
      case (r)
         0: return 3'b010;
         1: return 3'b100;
         default: return 3'b001;
      endcase
   endfunction

   initial begin
      rst_n = 0;
      idle_ctl();
      pred_PC = '0;
      f_stat = 3'b001; f_iCode = 0; f_iFun = 0; f_rA = 0; f_rB = 0; f_valC = 0; f_valP = 0;
      m_stat = 3'b001; M_iCode = 0; M_rA = 0; M_rB = 0;
      M_valC = 0; M_valP = 0; M_valA = 0; M_valB = 0; M_valE = 0; m_valM = 0; M_Cnd = 0;

      repeat (2) @(posedge clk);
      #1;
      mdl = bubble_state();
      check_all(mdl);
      $display("reset: F_predPC=%0h D_iCode=%0h D_stat=%0b W_iCode=%0h", F_predPC, D_iCode, D_stat, W_iCode);
      @(negedge clk);
      rst_n = 1;

      // Basic load into F and D.
      f_iCode = 4'h3; f_rB = 4'h2; f_rA = 4'hF; f_valC = 64'd100; f_valP = 64'd30; pred_PC = 64'd30;
      step();
      // D stall holds against new fetch fields; stall outranks bubble.
      f_iCode = 4'h6; f_valC = 64'd555; pred_PC = 64'd44; D_stall = 1;
      step();
      D_bubble = 1;
      step();
      // Bubble alone inserts a NOP.
      D_stall = 0;
      step();
      D_bubble = 0;
      step();
      // W capture, then W stall holding across new inputs.
      M_iCode = 4'h5; m_valM = 64'd77; M_Cnd = 1; M_rA = 4'h3; M_rB = 4'h4;
      M_valE = 64'hDEAD_BEEF_0000_0001; M_valA = 64'd11; M_valB = 64'd22; M_valC = 64'd33; M_valP = 64'd44;
      step();
      W_stall = 1; M_iCode = 4'h7; m_valM = 64'd9; M_Cnd = 0;
      step();
      step();
      W_stall = 0; F_stall = 1; pred_PC = 64'h1234;
      step();
      F_stall = 0;
      step();

      // Randomised traffic with mostly-AOK status.
      for (int i = 0; i < 40; i++) begin
         F_stall  = ($urandom_range(0, 3) == 0);
         D_stall  = ($urandom_range(0, 3) == 0);
         D_bubble = ($urandom_range(0, 3) == 0);
         W_stall  = ($urandom_range(0, 3) == 0);
         pred_PC  = {$urandom, $urandom};
         f_stat   = pick_stat(int'($urandom_range(0, 9)));
         f_iCode  = 4'($urandom); f_iFun = 4'($urandom); f_rA = 4'($urandom); f_rB = 4'($urandom);
         f_valC   = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
         m_stat   = 3'b001;
         M_iCode  = 4'($urandom); M_rA = 4'($urandom); M_rB = 4'($urandom);
         M_valC   = {$urandom, $urandom}; M_valP = {$urandom, $urandom};
         M_valA   = {$urandom, $urandom}; M_valB = {$urandom, $urandom};
         M_valE   = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
         M_Cnd    = 1'($urandom);
         step();
      end

      // Halt status reaching W, then further changes.
      idle_ctl();
      m_stat = 3'b100; M_iCode = 4'h0;
      step();
      m_stat = 3'b001;
      for (int i = 0; i < 4; i++) begin
         pred_PC = 64'h100 + 64'(i); f_iCode = 4'(i + 2); M_iCode = 4'(i + 8); m_valM = 64'(i * 3);
         D_bubble = (i == 2);
         step();
      end

      // Asynchronous reset mid-cycle, with stalls active.
      F_stall = 1; D_stall = 1; W_stall = 1;
      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      mdl = bubble_state();
      n_step++;
      check_all(mdl);
      $display("async reset: F_predPC=%0h D_iCode=%0h W_iCode=%0h", F_predPC, D_iCode, W_iCode);
      @(negedge clk);
      rst_n = 1;
      idle_ctl();
      pred_PC = 64'd88; f_iCode = 4'hA; M_iCode = 4'hB; m_stat = 3'b001;
      step();
      step();

      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
